tx_medida_sequencer: RTL and testbench

- Sits between the HC-SR04 interface (12-bit BCD medida, 3 digits) and the 7O1 serial transmitter (tx_serial_7O1).
- On a send request, captures the measurement and converts each BCD digit to 7-bit ASCII. Issues four transmitter requests in order: hundreds, tens, units, then terminator '#'.
- Handles the partida/pronto handshake with the transmitter per character and reports frame completion or timeout.

---
 rtl/tx_medida_sequencer.sv | 156 +++++++++++++++
 tb/tb_tx_medida_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_medida_sequencer.sv
// -----------------------------------------------------------------------------
// tx_medida_sequencer
//
// Purpose:
//   Sends one HC-SR04 measurement (three BCD digits) over the 7O1 serial
//   transmitter as ASCII text: hundreds, tens, units, then TERMINADOR.
//   With TX_MEDIDA_CRLF_EN defined, CR (0x0D) and LF (0x0A) follow the
//   terminator, giving six characters per frame. Without it, the frame has
//   four characters and no CR/LF logic is built.
//
// Handshake with the transmitter (one exchange per character):
//   tx_partida is a one-cycle start pulse. tx_dados_ascii is valid while
//   tx_partida is high and stays stable until the transmitter answers.
//   The transmitter answers with a one-cycle tx_pronto pulse at the end of
//   its frame. If no tx_pronto arrives within TIMEOUT_CICLOS cycles of
//   waiting, the frame is aborted and erro pulses. tx_pronto is only
//   honoured while the sequencer is waiting.
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high reset
//   enviar         in   one-cycle send request (ignored while busy)
//   medida         in   [11:8] hundreds, [7:4] tens, [3:0] units (BCD)
//   tx_pronto      in   one-cycle end-of-character pulse from transmitter
//   tx_partida     out  one-cycle start pulse to transmitter
//   tx_dados_ascii out  character for the transmitter
//   pronto         out  one-cycle pulse: whole frame sent
//   erro           out  one-cycle pulse: frame aborted on timeout
//   db_estado      out  state code (inicial 0 .. final 5, erro E)
//
// Parameters:
//   TERMINADOR      ASCII code sent after the three digits
//   TIMEOUT_CICLOS  maximum number of cycles spent waiting for tx_pronto
// -----------------------------------------------------------------------------
module tx_medida_sequencer #(
  parameter logic [6:0] TERMINADOR     = 7'h23,
  parameter int         TIMEOUT_CICLOS = 10000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enviar,
  input  logic [11:0] medida,
  input  logic        tx_pronto,
  output logic        tx_partida,
  output logic [6:0]  tx_dados_ascii,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int CNT_W = $clog2(TIMEOUT_CICLOS + 1);

`ifdef TX_MEDIDA_CRLF_EN
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] ULTIMO = 3'd5;
`else
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] ULTIMO = 2'd3;
`endif

  typedef enum logic [3:0] {
    INICIAL   = 4'h0,
    REGISTRA  = 4'h1,
    TRANSMITE = 4'h2,
    ESPERA    = 4'h3,
    PROXIMO   = 4'h4,
    FINAL     = 4'h5,
    ERRO      = 4'hE
  } estado_t;

  estado_t          estado;
  logic [11:0]      medida_reg;
  logic [IDX_W-1:0] indice;
  logic [CNT_W-1:0] contador;

  // Character for a given position of the frame. Nibbles A-F are passed
  // through unchanged and come out as 0x3A-0x3F.
  function automatic logic [6:0] caractere(input logic [11:0]      m,
                                           input logic [IDX_W-1:0] i);
    logic [6:0] c;
    case (i)
      IDX_W'(0): c = {3'b011, m[11:8]};
      IDX_W'(1): c = {3'b011, m[7:4]};
      IDX_W'(2): c = {3'b011, m[3:0]};
`ifdef TX_MEDIDA_CRLF_EN
      IDX_W'(4): c = 7'h0D;
      IDX_W'(5): c = 7'h0A;
`endif
      default:   c = TERMINADOR;
    endcase
    return c;
  endfunction

  assign db_estado = estado;

  // Output registers are loaded on the transition into the state that owns
  // them, so each output is high exactly while that state is current.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= INICIAL;
      medida_reg     <= '0;
      indice         <= '0;
      contador       <= '0;
      tx_partida     <= 1'b0;
      tx_dados_ascii <= '0;
      pronto         <= 1'b0;
      erro           <= 1'b0;
    end else begin
      tx_partida <= 1'b0;
      pronto     <= 1'b0;
      erro       <= 1'b0;
      case (estado)
        INICIAL: begin
          if (enviar) estado <= REGISTRA;
        end
        REGISTRA: begin
          // The frame works only from medida_reg from here on.
          medida_reg     <= medida;
          indice         <= '0;
          tx_dados_ascii <= caractere(medida, '0);
          tx_partida     <= 1'b1;
          estado         <= TRANSMITE;
        end
        TRANSMITE: begin
          contador <= '0;
          estado   <= ESPERA;
        end
        ESPERA: begin
          contador <= contador + 1'b1;
          // tx_pronto is checked first so it wins a tie with the timeout.
          if (tx_pronto) begin
            estado <= PROXIMO;
          end else if (contador + 1'b1 == CNT_W'(TIMEOUT_CICLOS)) begin
            estado <= ERRO;
            erro   <= 1'b1;
          end
        end
        PROXIMO: begin
          indice <= indice + 1'b1;
          if (indice == ULTIMO) begin
            estado <= FINAL;
            pronto <= 1'b1;
          end else begin
            tx_dados_ascii <= caractere(medida_reg, indice + 1'b1);
            tx_partida     <= 1'b1;
            estado         <= TRANSMITE;
          end
        end
        FINAL:   estado <= INICIAL;
        ERRO:    estado <= INICIAL;
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_medida_sequencer.sv
module tb_tx_medida_sequencer;

  localparam int TOUT = 50;
`ifdef TX_MEDIDA_CRLF_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 4;
`endif

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enviar = 1'b0;
  logic [11:0] medida = '0;
  logic        tx_pronto = 1'b0;
  logic        tx_partida;
  logic [6:0]  tx_dados_ascii;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  always #5 clock = ~clock;

  tx_medida_sequencer #(
    .TERMINADOR(7'h23),
    .TIMEOUT_CICLOS(TOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enviar(enviar),
    .medida(medida),
    .tx_pronto(tx_pronto),
    .tx_partida(tx_partida),
    .tx_dados_ascii(tx_dados_ascii),
    .pronto(pronto),
    .erro(erro),
    .db_estado(db_estado)
  );

  int vectors = 0;
  int miscompares = 0;

  // pulse counters, sampled on the rising edge (value of the previous cycle)
  int n_partida = 0;
  int n_pronto = 0;
  int n_erro = 0;
  always @(posedge clock) begin
    if (tx_partida === 1'b1) n_partida++;
    if (pronto === 1'b1) n_pronto++;
    if (erro === 1'b1) n_erro++;
  end

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  logic [6:0] got_q[$];

  function automatic void push_exp(input logic [11:0] m);
    exp_q.delete();
    exp_q.push_back({3'b011, m[11:8]});
    exp_q.push_back({3'b011, m[7:4]});
    exp_q.push_back({3'b011, m[3:0]});
    exp_q.push_back(7'h23);
`ifdef TX_MEDIDA_CRLF_EN
    exp_q.push_back(7'h0D);
    exp_q.push_back(7'h0A);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_counts();
    n_partida = 0;
    n_pronto = 0;
    n_erro = 0;
  endtask

  task automatic start_frame(input logic [11:0] m);
    medida = m;
    got_q.delete();
    enviar = 1'b1;
    tick();
    enviar = 1'b0;
  endtask

  // Waits for tx_partida, records the character, answers 20 cycles later.
  // poke_kind at cycle poke_at: 1 = enviar pulse, 2 = change medida,
  // 3 = one-cycle reset (returns without answering).
  task automatic serve_char(input int poke_at, input int poke_kind, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100 && tx_partida !== 1'b1; t++) tick();
    if (tx_partida !== 1'b1) return;
    got_q.push_back(tx_dados_ascii);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == poke_at) begin
        case (poke_kind)
          1: begin enviar = 1'b1; tick(); enviar = 1'b0; end
          2: medida = 12'h999;
          3: begin reset = 1'b1; tick(); reset = 1'b0; ok = 1'b1; return; end
          default: ;
        endcase
      end
    end
    tx_pronto = 1'b1;
    tick();
    tx_pronto = 1'b0;
    ok = 1'b1;
  endtask

  task automatic serve_all(input int poke_char, input int poke_at, input int poke_kind);
    bit ok;
    for (int c = 0; c < NCH; c++) begin
      serve_char((c == poke_char) ? poke_at : 0, poke_kind, ok);
      if (!ok) break;
      if (poke_kind == 3 && c == poke_char) break;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (db_estado !== 4'h0 || tx_partida !== 1'b0 || tx_dados_ascii !== 7'h00 ||
        pronto !== 1'b0 || erro !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: estado=%h partida=%b dados=%h pronto=%b erro=%b, required 0 0 00 0 0",
               db_estado, tx_partida, tx_dados_ascii, pronto, erro);
    end
  endtask

  task automatic test_basic();
    clear_counts();
    push_exp(12'h123);
    start_frame(12'h123);
    vectors++;
    if (db_estado !== 4'h1 || tx_partida !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_registra: estado=%h partida=%b, required 1 0", db_estado, tx_partida);
    end
    tick();
    vectors++;
    if (db_estado !== 4'h2 || tx_partida !== 1'b1 || tx_dados_ascii !== 7'h31) begin
      miscompares++;
      $display("FAIL basic_latency: estado=%h partida=%b dados=%h, required 2 1 31",
               db_estado, tx_partida, tx_dados_ascii);
    end
    serve_all(-1, 0, 0);
    vectors++;
    if (db_estado !== 4'h4 || pronto !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_proximo: estado=%h pronto=%b, required 4 0", db_estado, pronto);
    end
    tick();
    vectors++;
    if (db_estado !== 4'h5 || pronto !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_pronto: estado=%h pronto=%b, required 5 1", db_estado, pronto);
    end
    tick();
    vectors++;
    if (db_estado !== 4'h0 || pronto !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_end: estado=%h pronto=%b, required 0 0", db_estado, pronto);
    end
    vectors++;
    if (got_q.size() != NCH || n_partida != NCH || n_pronto != 1 || n_erro != 0) begin
      miscompares++;
      $display("FAIL basic_counts: chars=%0d partida=%0d pronto=%0d erro=%0d, required %0d %0d 1 0",
               got_q.size(), n_partida, n_pronto, n_erro, NCH, NCH);
    end
    for (int i = 0; i < NCH && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL basic_char%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_capture();
    push_exp(12'h405);
    start_frame(12'h405);
    serve_all(0, 3, 2);
    tick();
    tick();
    vectors++;
    if (got_q.size() != NCH) begin
      miscompares++;
      $display("FAIL capture_len: got %0d chars, required %0d", got_q.size(), NCH);
    end
    for (int i = 0; i < NCH && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL capture_char%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_busy();
    clear_counts();
    push_exp(12'h321);
    start_frame(12'h321);
    serve_all(1, 5, 1);
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (n_partida != NCH || n_pronto != 1 || db_estado !== 4'h0) begin
      miscompares++;
      $display("FAIL busy_ignore: partida=%0d pronto=%0d estado=%h, required %0d 1 0",
               n_partida, n_pronto, db_estado, NCH);
    end
    for (int i = 0; i < NCH && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL busy_char%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    clear_counts();
    start_frame(12'h555);
    tick();
    vectors++;
    if (tx_partida !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_start: partida=%b, required 1", tx_partida);
    end
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 50) begin
        vectors++;
        if (erro !== 1'b0 || db_estado !== 4'h3) begin
          miscompares++;
          $display("FAIL timeout_wait: erro=%b estado=%h, required 0 3", erro, db_estado);
        end
      end
      if (k == 51) begin
        vectors++;
        if (erro !== 1'b1 || db_estado !== 4'hE) begin
          miscompares++;
          $display("FAIL timeout_erro: erro=%b estado=%h, required 1 E", erro, db_estado);
        end
      end
      if (k == 52) begin
        vectors++;
        if (erro !== 1'b0 || db_estado !== 4'h0) begin
          miscompares++;
          $display("FAIL timeout_back: erro=%b estado=%h, required 0 0", erro, db_estado);
        end
      end
    end
    vectors++;
    if (n_erro != 1 || n_pronto != 0 || n_partida != 1) begin
      miscompares++;
      $display("FAIL timeout_counts: erro=%0d pronto=%0d partida=%0d, required 1 0 1",
               n_erro, n_pronto, n_partida);
    end
  endtask

  task automatic test_reset_mid();
    start_frame(12'h678);
    serve_all(2, 5, 3);
    vectors++;
    if (db_estado !== 4'h0 || tx_partida !== 1'b0 || tx_dados_ascii !== 7'h00 ||
        pronto !== 1'b0 || erro !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: estado=%h partida=%b dados=%h pronto=%b erro=%b, required 0 0 00 0 0",
               db_estado, tx_partida, tx_dados_ascii, pronto, erro);
    end
    clear_counts();
    for (int i = 0; i < 30; i++) tick();
    vectors++;
    if (n_partida != 0 || db_estado !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_quiet: partida=%0d estado=%h, required 0 0", n_partida, db_estado);
    end
    push_exp(12'h246);
    start_frame(12'h246);
    serve_all(-1, 0, 0);
    tick();
    vectors++;
    if (pronto !== 1'b1 || got_q.size() != NCH) begin
      miscompares++;
      $display("FAIL reset_refr: pronto=%b chars=%0d, required 1 %0d", pronto, got_q.size(), NCH);
    end
    for (int i = 0; i < NCH && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_char%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    clear_counts();
    start_frame(12'h111);
    serve_all(-1, 0, 0);
    tick();
    vectors++;
    if (pronto !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_pronto1: pronto=%b, required 1", pronto);
    end
    tick();
    // first cycle after pronto: new request
    push_exp(12'hAF0);
    start_frame(12'hAF0);
    vectors++;
    if (db_estado !== 4'h1) begin
      miscompares++;
      $display("FAIL b2b_accept: estado=%h, required 1", db_estado);
    end
    serve_all(-1, 0, 0);
    tick();
    vectors++;
    if (pronto !== 1'b1 || n_partida != 2 * NCH) begin
      miscompares++;
      $display("FAIL b2b_pronto2: pronto=%b partida=%0d, required 1 %0d", pronto, n_partida, 2 * NCH);
    end
    for (int i = 0; i < NCH && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL nonbcd_char%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    tick();
  endtask

  task automatic test_crlf();
    push_exp(12'h070);
    start_frame(12'h070);
    serve_all(-1, 0, 0);
    tick();
    vectors++;
    if (pronto !== 1'b1 || got_q.size() != NCH) begin
      miscompares++;
      $display("FAIL crlf_frame: pronto=%b chars=%0d, required 1 %0d", pronto, got_q.size(), NCH);
    end
    for (int i = 0; i < NCH && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL crlf_char%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_capture();
    test_busy();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_crlf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
